// File: rtl/ysyx_22041071_axi_w_slave_pkg.sv
// Shared encodings for the AXI write-channel responder: burst types, response codes, FSM states.
package ysyx_22041071_axi_w_slave_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/ysyx_22041071_axi_w_slave.sv
// AXI4 write responder: one burst at a time, each W beat becomes a same-cycle write on a
// byte-strobed memory port, followed by a single B response.
//
// state | meaning
// IDLE  | waiting for AW, aw_ready high
// DATA  | accepting W beats while the memory is ready, beat counter runs to len
// RESP  | holding B until b_ready
module ysyx_22041071_axi_w_slave
  import ysyx_22041071_axi_w_slave_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [ID_WIDTH-1:0]     aw_id_i,
  input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [LEN_WIDTH-1:0]    aw_len_i,
  input  logic [2:0]              aw_size_i,
  input  logic [1:0]              aw_burst_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  input  logic [DATA_WIDTH-1:0]   w_data_i,
  input  logic [DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                    w_last_i,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  output logic [ID_WIDTH-1:0]     b_id_o,
  output logic [1:0]              b_resp_o,
  output logic                    mem_wen_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
  input  logic                    mem_ready_i
);

  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    cnt_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic                    err_q;

  logic                    aw_fire;
  logic                    w_fire;
  logic                    final_beat;
  logic                    last_bad;
  logic [ADDR_WIDTH-1:0]   addr_step;

  assign aw_fire    = (state_q == ST_IDLE) && aw_valid_i;
  assign w_fire     = (state_q == ST_DATA) && w_valid_i && mem_ready_i;
  assign final_beat = (cnt_q == len_q);
  // The counter alone ends the burst; w_last only serves as a consistency check.
  assign last_bad   = (w_last_i != final_beat);
  assign addr_step  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << size_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (aw_fire) state_d = ST_DATA;
      ST_DATA: if (w_fire && final_beat) state_d = ST_RESP;
      ST_RESP: if (b_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    aw_ready_o  = (state_q == ST_IDLE);
    w_ready_o   = (state_q == ST_DATA) && mem_ready_i;
    b_valid_o   = (state_q == ST_RESP);
    b_id_o      = '0;
    b_resp_o    = RESP_OKAY;
    if (state_q == ST_RESP) begin
      b_id_o   = id_q;
      b_resp_o = err_q ? RESP_SLVERR : RESP_OKAY;
    end
    // A beat that itself reveals a w_last mismatch is already suppressed.
    mem_wen_o   = w_fire && !err_q && !last_bad;
    mem_addr_o  = w_fire ? addr_q   : '0;
    mem_wdata_o = w_fire ? w_data_i : '0;
    mem_wstrb_o = w_fire ? w_strb_i : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
    end else if (aw_fire) begin
      id_q    <= aw_id_i;
      addr_q  <= aw_addr_i;
      len_q   <= aw_len_i;
      cnt_q   <= '0;
      size_q  <= aw_size_i;
      burst_q <= aw_burst_i;
      err_q   <= (aw_burst_i == BURST_WRAP) || (aw_burst_i == BURST_RSVD);
    end else if (w_fire) begin
      cnt_q <= cnt_q + 1'b1;
      if (burst_q == BURST_INCR) addr_q <= addr_q + addr_step;
      if (last_bad) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_axi_w_slave.sv
// Directed bench for the AXI write responder: table of bursts plus hand-written reset/idle cases.
module tb_ysyx_22041071_axi_w_slave;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        aw_valid_i, aw_ready_o;
  logic [3:0]  aw_id_i;
  logic [31:0] aw_addr_i;
  logic [7:0]  aw_len_i;
  logic [2:0]  aw_size_i;
  logic [1:0]  aw_burst_i;
  logic        w_valid_i, w_ready_o;
  logic [63:0] w_data_i;
  logic [7:0]  w_strb_i;
  logic        w_last_i;
  logic        b_valid_o, b_ready_i;
  logic [3:0]  b_id_o;
  logic [1:0]  b_resp_o;
  logic        mem_wen_o;
  logic [31:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_wstrb_o;
  logic        mem_ready_i;

  ysyx_22041071_axi_w_slave dut (
    .clk(clk), .reset_n(reset_n),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
    .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i), .aw_size_i(aw_size_i), .aw_burst_i(aw_burst_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i), .w_strb_i(w_strb_i),
    .w_last_i(w_last_i), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o),
    .b_resp_o(b_resp_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_ready_i(mem_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0]       id;
    int               last_mode;   // 0 normal, 1 last only on early_beat, 2 never
    int               early_beat;
    bit               bp;
    bit               bstall;
    int               exp_nwr;
    logic [1:0]       exp_resp;
    logic [3:0][31:0] exp_addr;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int nbeats = 0;
  logic [31:0] wq_addr[$];
  logic [63:0] wq_data[$];
  logic [7:0]  wq_strb[$];
  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [31:0] addr, logic [7:0] len, logic [2:0] size,
                              logic [1:0] burst, logic [3:0] id, int mode, int early,
                              bit bp, bit bstall, int nwr, logic [1:0] resp,
                              logic [31:0] a0, logic [31:0] a1, logic [31:0] a2, logic [31:0] a3);
    vec_t v;
    v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.id = id;
    v.last_mode = mode; v.early_beat = early; v.bp = bp; v.bstall = bstall;
    v.exp_nwr = nwr; v.exp_resp = resp;
    v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_addr[2] = a2; v.exp_addr[3] = a3;
    return v;
  endfunction

  function automatic logic [63:0] dat(int idx, int beat);
    return 64'h1122334455667788 + (64'(idx) << 16) + 64'(beat);
  endfunction

  function automatic logic [7:0] strb(int idx, int beat);
    return (idx == 0) ? 8'hFF : (8'hFF >> beat);
  endfunction

  always @(negedge clk) begin
    if (reset_n && w_valid_i && w_ready_o) nbeats++;
    if (mem_wen_o) begin
      wq_addr.push_back(mem_addr_o);
      wq_data.push_back(mem_wdata_o);
      wq_strb.push_back(mem_wstrb_o);
    end
  end

  task automatic run_vec(input int i);
    vec_t v;
    bit got;
    logic [3:0] id0;
    logic [1:0] resp0;
    v = vecs[i];
    wq_addr.delete(); wq_data.delete(); wq_strb.delete();
    nbeats = 0;
    @(posedge clk); #1;
    aw_valid_i = 1; aw_addr_i = v.addr; aw_len_i = v.len; aw_size_i = v.size;
    aw_burst_i = v.burst; aw_id_i = v.id;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk); got = aw_ready_o;
      @(posedge clk); #1;
    end
    aw_valid_i = 0;
    if (!got) chk($sformatf("v%0d aw_timeout", i), 0, 1);
    mem_ready_i = v.bp ? 1'b0 : 1'b1;
    for (int b = 0; b <= int'(v.len); b++) begin
      w_valid_i = 1; w_data_i = dat(i, b); w_strb_i = strb(i, b);
      w_last_i = (v.last_mode == 0) ? (b == int'(v.len)) :
                 (v.last_mode == 1) ? (b == v.early_beat) : 1'b0;
      got = 0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk);
        got = w_ready_o;
        if (v.bp) chk($sformatf("v%0d w_ready_tracks", i), w_ready_o, mem_ready_i);
        @(posedge clk); #1;
        if (v.bp) mem_ready_i = ~mem_ready_i;
      end
      if (!got) chk($sformatf("v%0d w_timeout b%0d", i, b), 0, 1);
    end
    w_valid_i = 0; w_last_i = 0; mem_ready_i = 1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk); got = b_valid_o;
      if (!got) begin @(posedge clk); #1; end
    end
    if (!got) chk($sformatf("v%0d b_timeout", i), 0, 1);
    if (v.bstall) begin
      id0 = b_id_o; resp0 = b_resp_o;
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1; @(negedge clk);
        chk($sformatf("v%0d stall_bvalid c%0d", i, c), b_valid_o, 1);
        chk($sformatf("v%0d stall_bid c%0d", i, c), b_id_o, id0);
        chk($sformatf("v%0d stall_bresp c%0d", i, c), b_resp_o, resp0);
        chk($sformatf("v%0d stall_awready c%0d", i, c), aw_ready_o, 0);
      end
    end
    chk($sformatf("v%0d b_id", i), b_id_o, v.id);
    chk($sformatf("v%0d b_resp", i), b_resp_o, v.exp_resp);
    @(posedge clk); #1; b_ready_i = 1;
    @(negedge clk); chk($sformatf("v%0d b_valid_hs", i), b_valid_o, 1);
    @(posedge clk); #1; b_ready_i = 0;
    @(negedge clk);
    chk($sformatf("v%0d idle_awready", i), aw_ready_o, 1);
    chk($sformatf("v%0d idle_bvalid", i), b_valid_o, 0);
    chk($sformatf("v%0d beats", i), nbeats, int'(v.len) + 1);
    chk($sformatf("v%0d nwrites", i), wq_addr.size(), v.exp_nwr);
    for (int k = 0; k < v.exp_nwr && k < wq_addr.size(); k++) begin
      chk($sformatf("v%0d wr%0d addr", i, k), wq_addr[k], v.exp_addr[k]);
      chk($sformatf("v%0d wr%0d data", i, k), wq_data[k], dat(i, k));
      chk($sformatf("v%0d wr%0d strb", i, k), wq_strb[k], strb(i, k));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = mk(32'h8000_0010, 0, 3, 2'b01, 5, 0, 0, 0, 0, 1, 2'b00, 32'h8000_0010, 0, 0, 0);
    vecs[1] = mk(32'h8000_0000, 3, 3, 2'b01, 1, 0, 0, 0, 1, 4, 2'b00,
                 32'h8000_0000, 32'h8000_0008, 32'h8000_0010, 32'h8000_0018);
    vecs[2] = mk(32'h8000_0000, 3, 3, 2'b01, 2, 0, 0, 1, 0, 4, 2'b00,
                 32'h8000_0000, 32'h8000_0008, 32'h8000_0010, 32'h8000_0018);
    vecs[3] = mk(32'h1000_0000, 2, 3, 2'b00, 3, 0, 0, 0, 0, 3, 2'b00,
                 32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 0);
    vecs[4] = mk(32'h8000_0100, 3, 3, 2'b01, 4, 1, 1, 0, 0, 1, 2'b10, 32'h8000_0100, 0, 0, 0);
    vecs[5] = mk(32'h0000_2000, 1, 3, 2'b11, 6, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0);
    vecs[6] = mk(32'hFFFF_FFF8, 2, 2, 2'b01, 7, 0, 0, 0, 0, 3, 2'b00,
                 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 0);
    vecs[7] = mk(32'h0000_0040, 1, 3, 2'b01, 8, 2, 0, 0, 0, 1, 2'b10, 32'h0000_0040, 0, 0, 0);
    vecs[8] = mk(32'h0000_0080, 1, 3, 2'b10, 9, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0);

    reset_n = 0; aw_valid_i = 0; aw_id_i = 0; aw_addr_i = 0; aw_len_i = 0; aw_size_i = 0;
    aw_burst_i = 0; w_valid_i = 0; w_data_i = 0; w_strb_i = 0; w_last_i = 0;
    b_ready_i = 0; mem_ready_i = 1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst aw_ready", aw_ready_o, 1);
    chk("rst w_ready", w_ready_o, 0);
    chk("rst b_valid", b_valid_o, 0);
    chk("rst b_id", b_id_o, 0);
    chk("rst b_resp", b_resp_o, 0);
    chk("rst mem_wen", mem_wen_o, 0);
    chk("rst mem_addr", mem_addr_o, 0);
    @(posedge clk); #1; reset_n = 1;

    // W presented in IDLE must not be taken
    w_valid_i = 1; w_data_i = 64'hDEAD; w_strb_i = 8'hFF; w_last_i = 1;
    @(negedge clk);
    chk("idle w_ready", w_ready_o, 0);
    chk("idle mem_wen", mem_wen_o, 0);
    @(posedge clk); #1; w_valid_i = 0; w_last_i = 0;

    for (int i = 0; i < 9; i++) run_vec(i);

    // Reset in the middle of a burst: beat 2 of len=3
    @(posedge clk); #1;
    aw_valid_i = 1; aw_addr_i = 32'h3000; aw_len_i = 3; aw_size_i = 3; aw_burst_i = 2'b01; aw_id_i = 4'hA;
    @(negedge clk); chk("mid aw_ready", aw_ready_o, 1);
    @(posedge clk); #1; aw_valid_i = 0;
    for (int b = 0; b < 2; b++) begin
      w_valid_i = 1; w_data_i = 64'(b); w_strb_i = 8'hFF; w_last_i = 0;
      @(negedge clk); chk($sformatf("mid beat%0d accepted", b), w_ready_o, 1);
      @(posedge clk); #1;
    end
    w_data_i = 64'd2; reset_n = 0;
    @(posedge clk); #1; reset_n = 1; w_valid_i = 0;
    @(negedge clk);
    chk("mid post_rst aw_ready", aw_ready_o, 1);
    chk("mid post_rst w_ready", w_ready_o, 0);
    chk("mid post_rst b_valid", b_valid_o, 0);
    chk("mid post_rst mem_wen", mem_wen_o, 0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1; @(negedge clk);
      chk($sformatf("mid no_b c%0d", c), b_valid_o, 0);
    end
    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
